// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution stream controller.
// Holds the sequencer state encoding, the stride select encoding and
// the output-geometry helpers used by the top and the coordinate tracker.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // Encoding of the stride2 input / latched stride select
    localparam logic STRIDE_1 = 1'b0;
    localparam logic STRIDE_2 = 1'b1;

    // Number of valid window positions along one image axis
    function automatic int out_dim(input int img, input int filt);
        return img - filt + 1;
    endfunction

    // Largest even index inside an axis of n window positions
    function automatic int last_even(input int n);
        return (n - 1) & ~1;
    endfunction

endpackage

// File: rtl/conv_out_coord.sv
// Output coordinate tracker for the sliding-window buffer.
// Counts every window the buffer reports in raster order, qualifies them for
// stride 1 / stride 2, and flags the final qualified window of the frame.
// Outputs are combinational from buf_valid so they line up with window data.
module conv_out_coord
    import conv_pkg::*;
#(
    parameter int OUT_W     = 24,
    parameter int OUT_H     = 24,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 stride2,
    input  logic                 buf_valid,
    output logic                 win_valid,
    output logic [ADDR_BITS-1:0] out_row,
    output logic [ADDR_BITS-1:0] out_col,
    output logic                 out_last,
    output logic                 frame_end
);

    localparam logic [ADDR_BITS-1:0] COL_MAX   = ADDR_BITS'(OUT_W - 1);
    localparam logic [ADDR_BITS-1:0] ROW_MAX   = ADDR_BITS'(OUT_H - 1);
    localparam logic [ADDR_BITS-1:0] COL_LAST2 = ADDR_BITS'(last_even(OUT_W));
    localparam logic [ADDR_BITS-1:0] ROW_LAST2 = ADDR_BITS'(last_even(OUT_H));

    logic [ADDR_BITS-1:0] row;
    logic [ADDR_BITS-1:0] col;
    logic                 step;

    // Raw window position: col runs fastest, both wrap after the last window
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + ADDR_BITS'(1);
            end else begin
                col <= col + ADDR_BITS'(1);
            end
        end
    end

    // Stride qualification and last-window detection, zero latency
    always_comb begin
        step      = en & buf_valid;
        frame_end = step && (col == COL_MAX) && (row == ROW_MAX);
        win_valid = 1'b0;
        out_row   = row;
        out_col   = col;
        out_last  = 1'b0;
        if (stride2 == STRIDE_2) begin
            win_valid = step && !row[0] && !col[0];
            out_row   = row >> 1;
            out_col   = col >> 1;
            out_last  = win_valid && (row == ROW_LAST2) && (col == COL_LAST2);
        end else begin
            win_valid = step;
            out_last  = step && (row == ROW_MAX) && (col == COL_MAX);
        end
    end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Convolution frame sequencer for the 5x5 sliding-window line buffer.
// Clears the buffer, streams the image from memory in raster order with
// one-cycle read latency, qualifies buffer windows for the selected stride
// and reports frame completion.
// Optional build macro CONV_STREAM_PERF_EN adds perf_cycles/perf_stalls.
module conv_stream_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int DATA_BITS   = 8,
    parameter int FILTER_SIZE = 5,
    parameter int ADDR_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stride2,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_clr,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 buf_in_val,
    output logic [DATA_BITS-1:0] buf_data,
    input  logic                 buf_valid,
    input  logic                 out_ready,
    output logic                 win_valid,
    output logic [ADDR_BITS-1:0] out_row,
    output logic [ADDR_BITS-1:0] out_col,
    output logic                 out_last
`ifdef CONV_STREAM_PERF_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls
`endif
);

    localparam int                   NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);

    state_t state;
    logic   stride_q;
    logic   pix_vld;
    logic   accept;
    logic   frame_end;

    assign accept = (state == IDLE) && start;

    // Read strobe follows out_ready in the same cycle so that only the one
    // read already issued can still land after downstream pauses.
    assign mem_rd_en = (state == FETCH) && out_ready;

    // Frame sequencer with registered busy/done/clear outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_addr <= '0;
            stride_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            buf_clr  <= 1'b0;
        end else begin
            done    <= 1'b0;
            buf_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stride_q <= stride2;
                        mem_addr <= '0;
                        buf_clr  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: state <= FETCH;
                FETCH: begin
                    if (out_ready) begin
                        if (mem_addr == LAST_ADDR) begin
                            mem_addr <= '0;
                            state    <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (frame_end) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel valid trails the read strobe by the memory latency
    always_ff @(posedge clk) begin
        if (rst) pix_vld <= 1'b0;
        else     pix_vld <= mem_rd_en;
    end

    assign buf_in_val = pix_vld;
    assign buf_data   = pix_vld ? mem_rd_data : '0;

    conv_out_coord #(
        .OUT_W     (out_dim(WIDTH, FILTER_SIZE)),
        .OUT_H     (out_dim(HEIGHT, FILTER_SIZE)),
        .ADDR_BITS (ADDR_BITS)
    ) u_coord (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .en        ((state == FETCH) || (state == DRAIN)),
        .stride2   (stride_q),
        .buf_valid (buf_valid),
        .win_valid (win_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .frame_end (frame_end)
    );

`ifdef CONV_STREAM_PERF_EN
    // Frame cycle and stall counters, cleared at accepted start, held after done
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (state != IDLE)
                perf_cycles <= perf_cycles + 32'd1;
            if ((state == FETCH) && !out_ready)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Self-checking bench for conv_stream_ctrl: memory model, a behavioural
// stand-in for the 5x5 window buffer, and a window/pixel reference model.
module tb_conv_stream_ctrl;

    localparam int W = 28, H = 28, F = 5, AB = 10, DB = 8;
    localparam int NPIX = W * H, OW = W - F + 1, OH = H - F + 1;

    typedef struct packed {
        logic          last;
        logic [AB-1:0] row;
        logic [AB-1:0] col;
    } win_t;

    logic          clk = 1'b0;
    logic          rst, start, stride2;
    logic          busy, done, buf_clr, mem_rd_en;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_rd_data = '0;
    logic          buf_in_val;
    logic [DB-1:0] buf_data;
    logic          buf_valid = 1'b0;
    logic          out_ready;
    logic          win_valid, out_last;
    logic [AB-1:0] out_row, out_col;
`ifdef CONV_STREAM_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
    int            base_cycles = 0;
`endif

    int compares = 0, mismatches = 0;

    logic [DB-1:0] mem [0:(1<<AB)-1];
    logic ready_man = 1'b1, rand_ready = 1'b0, rnd_bit = 1'b1;
    assign out_ready = rand_ready ? rnd_bit : ready_man;

    always #5 clk = ~clk;

    conv_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stride2(stride2),
        .busy(busy), .done(done), .buf_clr(buf_clr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .buf_in_val(buf_in_val), .buf_data(buf_data), .buf_valid(buf_valid),
        .out_ready(out_ready), .win_valid(win_valid),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
`ifdef CONV_STREAM_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    // Image memory, one-cycle read latency
    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    // Window buffer stand-in: a window is complete once a pixel at raster
    // position (r,c) with r,c >= F-1 has been shifted in.
    int pix_cnt = 0;
    always @(posedge clk) begin
        if (buf_clr) begin
            pix_cnt   <= 0;
            buf_valid <= 1'b0;
        end else if (buf_in_val) begin
            buf_valid <= ((pix_cnt / W) >= F - 1) && ((pix_cnt % W) >= F - 1);
            pix_cnt   <= pix_cnt + 1;
        end else begin
            buf_valid <= 1'b0;
        end
    end

    // Monitor, sampled mid-cycle
    win_t          win_q[$];
    logic [DB-1:0] pix_q[$];
    win_t          exp_q[$];
    int            done_cnt = 0, clr_cnt = 0;
    always @(negedge clk) begin
        if (buf_in_val) pix_q.push_back(buf_data);
        if (win_valid)  win_q.push_back({out_last, out_row, out_col});
        if (done)       done_cnt <= done_cnt + 1;
        if (buf_clr)    clr_cnt  <= clr_cnt + 1;
        rnd_bit <= ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input bit s2);
        start = 1'b1; stride2 = s2;
        tick();
        start = 1'b0; stride2 = ~s2;
    endtask

    task automatic wait_done(output bit ok);
        int base;
        base = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            tick();
            if (done_cnt != base) ok = 1'b1;
        end
    endtask

    // Reference window list: every raster position, stride 2 keeps even/even
    // positions halved; the final entry of the frame carries last.
    task automatic build_exp(input bit s2);
        win_t t;
        exp_q.delete();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                if (!s2)
                    exp_q.push_back({1'b0, AB'(r), AB'(c)});
                else if (r % 2 == 0 && c % 2 == 0)
                    exp_q.push_back({1'b0, AB'(r / 2), AB'(c / 2)});
        t = exp_q.pop_back();
        t.last = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < (1 << AB); i++)
            mem[i] = ramp ? DB'(i) : DB'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        compares++; if (busy !== 1'b0) begin mismatches++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        compares++; if (done !== 1'b0) begin mismatches++; $display("FAIL reset_done: got %0b expected 0", done); end
        compares++; if (buf_clr !== 1'b0) begin mismatches++; $display("FAIL reset_clr: got %0b expected 0", buf_clr); end
        compares++; if (mem_rd_en !== 1'b0) begin mismatches++; $display("FAIL reset_rd_en: got %0b expected 0", mem_rd_en); end
        compares++; if (mem_addr !== '0) begin mismatches++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
        compares++; if ({buf_in_val, buf_data} !== '0) begin mismatches++; $display("FAIL reset_pixel: got %0h expected 0", {buf_in_val, buf_data}); end
        compares++; if ({win_valid, out_last, out_row, out_col} !== '0) begin mismatches++; $display("FAIL reset_window: got %0h expected 0", {win_valid, out_last, out_row, out_col}); end
`ifdef CONV_STREAM_PERF_EN
        compares++; if ({perf_cycles, perf_stalls} !== '0) begin mismatches++; $display("FAIL reset_perf: got %0h expected 0", {perf_cycles, perf_stalls}); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stride1();
        int wb, pb, db, bad; bit ok;
        fill_mem(1'b1);
        build_exp(1'b0);
        wb = win_q.size(); pb = pix_q.size(); db = done_cnt;
        start_frame(1'b0);
        compares++; if ({buf_clr, busy} !== 2'b11) begin mismatches++; $display("FAIL s1_clear_cycle: got %b expected 11", {buf_clr, busy}); end
        tick();
        compares++; if (buf_clr !== 1'b0) begin mismatches++; $display("FAIL s1_clear_width: got %0b expected 0", buf_clr); end
        wait_done(ok);
        compares++; if (!ok) begin mismatches++; $display("FAIL s1_done_timeout: got 0 expected 1"); end
        compares++; if (busy !== 1'b0) begin mismatches++; $display("FAIL s1_busy_at_done: got %0b expected 0", busy); end
        repeat (5) tick();
        compares++; if (done_cnt - db != 1) begin mismatches++; $display("FAIL s1_done_count: got %0d expected 1", done_cnt - db); end
        compares++; if (pix_q.size() - pb != NPIX) begin mismatches++; $display("FAIL s1_pixels: got %0d expected %0d", pix_q.size() - pb, NPIX); end
        bad = 0;
        for (int i = 0; i < NPIX && pb + i < pix_q.size(); i++)
            if (pix_q[pb + i] !== mem[i]) bad++;
        compares++; if (bad != 0) begin mismatches++; $display("FAIL s1_pixel_data: got %0d bad expected 0 bad", bad); end
        compares++; if (win_q.size() - wb != exp_q.size()) begin mismatches++; $display("FAIL s1_windows: got %0d expected %0d", win_q.size() - wb, exp_q.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && wb + i < win_q.size(); i++)
            if (win_q[wb + i] !== exp_q[i]) bad++;
        compares++; if (bad != 0) begin mismatches++; $display("FAIL s1_window_list: got %0d bad expected 0 bad", bad); end
`ifdef CONV_STREAM_PERF_EN
        compares++; if (perf_stalls !== 32'd0) begin mismatches++; $display("FAIL s1_perf_stalls: got %0d expected 0", perf_stalls); end
        compares++; if (perf_cycles !== 32'(NPIX + 4)) begin mismatches++; $display("FAIL s1_perf_cycles: got %0d expected %0d", perf_cycles, NPIX + 4); end
        base_cycles = int'(perf_cycles);
`endif
    endtask

    task automatic test_stride2();
        int wb, bad; bit ok;
        build_exp(1'b1);
        wb = win_q.size();
        start_frame(1'b1);
        wait_done(ok);
        compares++; if (!ok) begin mismatches++; $display("FAIL s2_done_timeout: got 0 expected 1"); end
        tick();
        compares++; if (win_q.size() - wb != OH * OW / 4) begin mismatches++; $display("FAIL s2_windows: got %0d expected %0d", win_q.size() - wb, OH * OW / 4); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && wb + i < win_q.size(); i++)
            if (win_q[wb + i] !== exp_q[i]) bad++;
        compares++; if (bad != 0) begin mismatches++; $display("FAIL s2_window_list: got %0d bad expected 0 bad", bad); end
    endtask

    task automatic test_backpressure();
        int wb, pb, wp, pp, bad, frz; bit ok;
        localparam int P = 12 * W + 7;
        fill_mem(1'b0);
        build_exp(1'b0);
        wb = win_q.size(); pb = pix_q.size();
        start_frame(1'b0);
        for (int i = 0; i < 2000 && mem_addr !== AB'(P); i++) tick();
        compares++; if (mem_addr !== AB'(P)) begin mismatches++; $display("FAIL bp_reach_addr: got %0d expected %0d", mem_addr, P); end
        ready_man = 1'b0;
        wp = win_q.size(); pp = pix_q.size(); frz = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_addr !== AB'(P) || mem_rd_en !== 1'b0) frz++;
        end
        compares++; if (frz != 0) begin mismatches++; $display("FAIL bp_addr_frozen: got %0d moving cycles expected 0", frz); end
        compares++; if (pix_q.size() - pp > 1) begin mismatches++; $display("FAIL bp_pixels_in_pause: got %0d expected <=1", pix_q.size() - pp); end
        compares++; if (win_q.size() - wp > 2) begin mismatches++; $display("FAIL bp_windows_in_pause: got %0d expected <=2", win_q.size() - wp); end
        ready_man = 1'b1;
        wait_done(ok);
        compares++; if (!ok) begin mismatches++; $display("FAIL bp_done_timeout: got 0 expected 1"); end
        tick();
        compares++; if (pix_q.size() - pb != NPIX) begin mismatches++; $display("FAIL bp_pixels: got %0d expected %0d", pix_q.size() - pb, NPIX); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && wb + i < win_q.size(); i++)
            if (win_q[wb + i] !== exp_q[i]) bad++;
        compares++; if (win_q.size() - wb != exp_q.size() || bad != 0) begin mismatches++; $display("FAIL bp_window_list: got %0d windows %0d bad expected %0d windows 0 bad", win_q.size() - wb, bad, exp_q.size()); end
`ifdef CONV_STREAM_PERF_EN
        compares++; if (perf_stalls !== 32'd10) begin mismatches++; $display("FAIL bp_perf_stalls: got %0d expected 10", perf_stalls); end
        compares++; if (perf_cycles !== 32'(base_cycles + 10)) begin mismatches++; $display("FAIL bp_perf_cycles: got %0d expected %0d", perf_cycles, base_cycles + 10); end
`endif
    endtask

    task automatic test_random_ready();
        int wb, pb, bad; bit ok, s2;
        for (int n = 0; n < 2; n++) begin
            fill_mem(1'b0);
            s2 = n[0] ^ 1'($urandom_range(0, 1));
            build_exp(s2);
            wb = win_q.size(); pb = pix_q.size();
            rand_ready = 1'b1;
            start_frame(s2);
            wait_done(ok);
            rand_ready = 1'b0;
            compares++; if (!ok) begin mismatches++; $display("FAIL rnd_done_timeout: got 0 expected 1"); end
            tick();
            bad = 0;
            for (int i = 0; i < NPIX && pb + i < pix_q.size(); i++)
                if (pix_q[pb + i] !== mem[i]) bad++;
            compares++; if (pix_q.size() - pb != NPIX || bad != 0) begin mismatches++; $display("FAIL rnd_pixels: got %0d pixels %0d bad expected %0d pixels 0 bad", pix_q.size() - pb, bad, NPIX); end
            bad = 0;
            for (int i = 0; i < exp_q.size() && wb + i < win_q.size(); i++)
                if (win_q[wb + i] !== exp_q[i]) bad++;
            compares++; if (win_q.size() - wb != exp_q.size() || bad != 0) begin mismatches++; $display("FAIL rnd_window_list: got %0d windows %0d bad expected %0d windows 0 bad", win_q.size() - wb, bad, exp_q.size()); end
        end
    endtask

    task automatic test_mid_reset();
        int wb, pb, db; bit ok;
        build_exp(1'b0);
        pb = pix_q.size(); db = done_cnt;
        start_frame(1'b0);
        for (int i = 0; i < 3000 && (pix_q.size() - pb) < 400; i++) tick();
        compares++; if (pix_q.size() - pb < 400) begin mismatches++; $display("FAIL mr_reach_pixel: got %0d expected 400", pix_q.size() - pb); end
        rst = 1'b1;
        tick();
        compares++; if ({busy, done, buf_clr, mem_rd_en, buf_in_val, win_valid} !== 6'b0) begin mismatches++; $display("FAIL mr_outputs: got %b expected 000000", {busy, done, buf_clr, mem_rd_en, buf_in_val, win_valid}); end
        compares++; if (mem_addr !== '0) begin mismatches++; $display("FAIL mr_addr: got %0d expected 0", mem_addr); end
        rst = 1'b0;
        repeat (3) tick();
        compares++; if (done_cnt != db || busy !== 1'b0) begin mismatches++; $display("FAIL mr_no_done: got %0d dones busy %0b expected 0 dones busy 0", done_cnt - db, busy); end
        wb = win_q.size();
        start_frame(1'b0);
        compares++; if (buf_clr !== 1'b1) begin mismatches++; $display("FAIL mr_reclear: got %0b expected 1", buf_clr); end
        wait_done(ok);
        compares++; if (!ok) begin mismatches++; $display("FAIL mr_done_timeout: got 0 expected 1"); end
        repeat (3) tick();
        compares++; if (done_cnt - db != 1) begin mismatches++; $display("FAIL mr_done_count: got %0d expected 1", done_cnt - db); end
        compares++; if (win_q.size() - wb != OH * OW) begin mismatches++; $display("FAIL mr_windows: got %0d expected %0d", win_q.size() - wb, OH * OW); end
    endtask

    task automatic test_start_ignored();
        int wb, db, cb, bad; bit seen;
        build_exp(1'b0);
        wb = win_q.size(); db = done_cnt; cb = clr_cnt;
        start_frame(1'b0);
        repeat (50) tick();
        start = 1'b1; stride2 = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        compares++; if (!seen) begin mismatches++; $display("FAIL si_done_timeout: got 0 expected 1"); end
        start = 1'b1; stride2 = 1'b0;
        tick();
        start = 1'b0;
        repeat (20) tick();
        compares++; if (busy !== 1'b0) begin mismatches++; $display("FAIL si_busy: got %0b expected 0", busy); end
        compares++; if (done_cnt - db != 1) begin mismatches++; $display("FAIL si_done_count: got %0d expected 1", done_cnt - db); end
        compares++; if (clr_cnt - cb != 1) begin mismatches++; $display("FAIL si_clear_count: got %0d expected 1", clr_cnt - cb); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && wb + i < win_q.size(); i++)
            if (win_q[wb + i] !== exp_q[i]) bad++;
        compares++; if (win_q.size() - wb != exp_q.size() || bad != 0) begin mismatches++; $display("FAIL si_window_list: got %0d windows %0d bad expected %0d windows 0 bad", win_q.size() - wb, bad, exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stride2 = 1'b0;
        test_reset();
        test_stride1();
        test_stride2();
        test_backpressure();
        test_random_ready();
        test_mid_reset();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
